// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game controller.
package breakout_pkg;

  typedef enum logic [2:0] {
    StNewGame,
    StPlay,
    StNewBall,
    StOver,
    StWin
  } state_e;

  // Frame tick fires on the first column of this line, outside the visible area.
  localparam logic [9:0] REFR_LINE = 10'd481;

  localparam logic [1:0] TextPlay    = 2'd0;
  localparam logic [1:0] TextNewGame = 2'd1;
  localparam logic [1:0] TextOver    = 2'd2;
  localparam logic [1:0] TextWin     = 2'd3;

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD score counter: synchronous clear, increment saturating at 99.
module bcd_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  logic [7:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 8'h00;
    end else if (inc && (q_q != 8'h99)) begin
      if (q_q[3:0] == 4'd9) begin
        q_d = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/breakout_ctrl.sv
// Breakout game-flow controller: start/ball/over sequencing, score and ball count.
// Define BREAKOUT_WIN_EN to add a WIN state entered when every brick is cleared.
module breakout_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = 3,
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  input  logic       all_clear,
  output logic       gra_still,
  output logic       game_over,
  output logic [7:0] score,
  output logic [1:0] balls_left,
  output logic [1:0] text_sel
);

  localparam int unsigned   TimerW    = $clog2(HOLD_FRAMES + 1);
  localparam logic [TimerW-1:0] HoldLoad = TimerW'(HOLD_FRAMES);
  localparam logic [1:0]    BallsInit = 2'(NUM_BALLS);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        balls_q, balls_d;
  logic [4:0]        btn_q;
  logic              armed_q;
  logic              gra_still_q, gra_still_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        text_sel_q, text_sel_d;
  logic              refr_tick, btn_press, score_clr, score_inc;

`ifndef BREAKOUT_WIN_EN
  logic unused_all_clear;
  assign unused_all_clear = all_clear;
`endif

  always_comb begin
    refr_tick = (pix_y == REFR_LINE) && (pix_x == 10'd0);
    // armed_q masks the first cycle after reset so a button held through reset is not a press
    btn_press = armed_q && (btn_q == 5'h00) && (btn != 5'h00);
    state_d   = state_q;
    balls_d   = balls_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    timer_d   = (refr_tick && (timer_q != '0)) ? timer_q - TimerW'(1) : timer_q;

    unique case (state_q)
      StNewGame: begin
        if (btn_press) begin
          state_d   = StPlay;
          score_clr = 1'b1;
          balls_d   = BallsInit;
        end
      end
      StPlay: begin
        score_inc = hit;
`ifdef BREAKOUT_WIN_EN
        if (all_clear) begin
          state_d = StWin;
          timer_d = HoldLoad;
        end else
`endif
        if (miss) begin
          balls_d = balls_q - 2'd1;
          state_d = (balls_q == 2'd1) ? StOver : StNewBall;
          timer_d = HoldLoad;
        end
      end
      StNewBall: begin
        if (btn_press && (timer_q == '0)) begin
          state_d = StPlay;
        end
      end
      StOver, StWin: begin
        if (timer_q == '0) begin
          state_d = StNewGame;
        end
      end
      default: state_d = StNewGame;
    endcase

    gra_still_d = (state_d != StPlay);
    game_over_d = (state_d == StOver) || (state_d == StWin);
    case (state_d)
      StNewGame: text_sel_d = TextNewGame;
      StOver:    text_sel_d = TextOver;
      StWin:     text_sel_d = TextWin;
      default:   text_sel_d = TextPlay;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StNewGame;
      timer_q     <= '0;
      balls_q     <= BallsInit;
      btn_q       <= 5'h00;
      armed_q     <= 1'b0;
      gra_still_q <= 1'b1;
      game_over_q <= 1'b0;
      text_sel_q  <= TextNewGame;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      balls_q     <= balls_d;
      btn_q       <= btn;
      armed_q     <= 1'b1;
      gra_still_q <= gra_still_d;
      game_over_q <= game_over_d;
      text_sel_q  <= text_sel_d;
    end
  end

  bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (score)
  );

  assign gra_still  = gra_still_q;
  assign game_over  = game_over_q;
  assign text_sel   = text_sel_q;
  assign balls_left = balls_q;

endmodule

// File: doc/breakout_ctrl.md
BREAKOUT_CTRL -- requirements
Module: breakout_ctrl

Interface
REQ-001 SHALL expose the following parameters:
- NUM_BALLS, 3, balls per game (1..3).
- HOLD_FRAMES, 120, frames the display holds in NEWBALL/OVER (2 s at 60 Hz).
REQ-002 SHALL expose the following ports (clock and reset first):
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- btn  in  5  raw player buttons, level.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- hit  in  1  one-cycle brick-hit pulse from the graphics stage.
- miss  in  1  one-cycle ball-lost pulse from the graphics stage.
- all_clear  in  1  level; every brick destroyed.
- gra_still  out  1  freeze graphics and restore initial positions.
- game_over  out  1  high in OVER (and WIN).
- score  out  8  two BCD digits, [7:4] tens, [3:0] units.
- balls_left  out  2  remaining balls.
- text_sel  out  2  overlay select: 0 play, 1 new-game, 2 over, 3 win.

Function
REQ-003 refr_tick SHALL be high when (pix_y==481 && pix_x==0), one cycle per frame.
REQ-004 btn_press SHALL be high for one cycle when btn goes from 5'h00 (previous-cycle registered value) to non-zero.
REQ-005 States SHALL be NEWGAME, PLAY, NEWBALL, OVER, plus WIN when BREAKOUT_WIN_EN is defined.
REQ-006 NEWGAME SHALL go to PLAY on btn_press, clearing score to 8'h00 and loading balls_left with NUM_BALLS on that same edge.
REQ-007 In PLAY, miss SHALL decrement balls_left. The FSM SHALL go to OVER if balls_left was 1, else to NEWBALL. Either transition SHALL load the timer with HOLD_FRAMES.
REQ-008 In PLAY, hit SHALL increment score by one in BCD: units 9 wraps to 0 with a tens carry; score saturates at 8'h99.
REQ-009 If hit and miss coincide in PLAY, both SHALL take effect in the same cycle.
REQ-010 hit and miss outside PLAY SHALL be ignored.
REQ-011 The timer SHALL decrement by 1 on each refr_tick while non-zero, and hold at 0.
REQ-012 NEWBALL SHALL go to PLAY on btn_press only when the timer is 0; earlier presses are discarded.
REQ-013 OVER SHALL go to NEWGAME when the timer reaches 0; score and balls_left hold until the next NEWGAME-to-PLAY transition.
REQ-014 gra_still SHALL be 1 in every state except PLAY; it is registered and changes on the cycle the state changes.
REQ-015 text_sel SHALL be 1 in NEWGAME, 2 in OVER, 3 in WIN, and 0 otherwise.
REQ-016 All outputs SHALL be registered, giving one-cycle latency from the triggering input.

Reset
REQ-017 Reset SHALL asynchronously force the following values, regardless of the state being left: NEWGAME, timer 0, score 8'h00, balls_left NUM_BALLS, gra_still 1, game_over 0, text_sel 1, btn history 0.

Configuration
REQ-018 With BREAKOUT_WIN_EN defined, all_clear high in PLAY SHALL go to WIN with the timer loaded. This takes priority over a simultaneous miss, and a simultaneous hit is still counted. WIN then behaves as OVER.
REQ-019 Without BREAKOUT_WIN_EN, all_clear SHALL be ignored, and text_sel value 3 SHALL never occur.

Structure
REQ-020 Package breakout_pkg SHALL hold the state encoding, REFR_LINE=481, and the text_sel codes.
REQ-021 The two-digit saturating BCD incrementer SHALL be sub-module bcd_counter (clk, reset, clr, inc, q[7:0]).

Verification
REQ-022 Directed scenarios:
- Reset during PLAY with score 8'h37 -> immediately NEWGAME, gra_still=1, score=8'h00.
- btn held at 5'h01 through reset release -> no start; release then press -> PLAY one cycle later, balls_left=3.
- 12 hit pulses from score 8'h08 -> 8'h20; 200 hits -> saturates at 8'h99.
- miss with balls_left=2 -> NEWBALL; press after 50 frames -> ignored; press after 120 frames -> PLAY.
- Third miss -> OVER, game_over=1, text_sel=2; 120 refr_ticks later -> NEWGAME, text_sel=1.
- BREAKOUT_WIN_EN, all_clear with miss and hit in the same cycle -> WIN, balls_left unchanged, score +1.
